// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU.
// The controller drives the request side, the consumer acks the result.
interface alu_seq_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   operand1;
  logic [N-1:0]   operand2;
  logic [3:0]     operation;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] alu_out;
  logic           zero;
  logic           div_err;

  modport master (
    output in_valid, operand1, operand2, operation, out_ready,
    input  in_ready, out_valid, alu_out, zero, div_err
  );

  modport slave (
    input  in_valid, operand1, operand2, operation, out_ready,
    output in_ready, out_valid, alu_out, zero, div_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential 16-op ALU with iterative shift-add multiplier
// and restoring divider behind valid/ready handshakes.
module alu_seq #(
  parameter int N = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  alu_seq_if.slave  bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    mc_q, mc_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [N-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mod_q, mod_d;
  logic [W-1:0]    res_q, res_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [W-1:0]    ax, bx, alu_r, prod;
  logic [N:0]      trial;
  logic [N-1:0]    rem_n, quo_n;
  logic            last, load, ld_err;
  logic [W-1:0]    ld_val;

  assign ax = W'(bus.operand1);
  assign bx = W'(bus.operand2);

  always_comb begin
    alu_r = '0;
    unique case (bus.operation)
      4'h0: alu_r = ax + bx;
      4'h1: alu_r = ax - bx;
      4'h5: alu_r = ax & bx;
      4'h6: alu_r = ax | bx;
      4'h7: alu_r = ax ^ bx;
      4'h8: alu_r = W'((|ax) && (|bx));
      4'h9: alu_r = W'((|ax) || (|bx));
      4'hA: alu_r = ax << 1;
      4'hB: alu_r = ax >> 1;
      4'hC: alu_r = W'(ax == bx);
      4'hD: alu_r = W'(ax != bx);
      4'hE: alu_r = W'(ax < bx);
      4'hF: alu_r = W'(ax > bx);
      default: alu_r = '0;
    endcase
  end

  // mc_q holds the shifting multiplicand, or the dividend/quotient
  assign prod  = acc_q + (b_q[0] ? mc_q : '0);
  assign trial = {acc_q[N-1:0], mc_q[N-1]} - {1'b0, b_q};
  assign rem_n = trial[N] ? {acc_q[N-2:0], mc_q[N-1]} : trial[N-1:0];
  assign quo_n = {mc_q[N-2:0], ~trial[N]};
  assign last  = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    load    = 1'b0;
    ld_val  = '0;
    ld_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (bus.operation)
            4'h2: begin
              mc_d    = ax;
              b_d     = bus.operand2;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = MUL;
            end
            4'h3, 4'h4: begin
              if (bus.operand2 == '0) begin
                load    = 1'b1;
                ld_err  = 1'b1;
                ld_val  = (bus.operation == 4'h4) ? '1 : ax;
                state_d = DONE;
              end else begin
                mc_d    = ax;
                b_d     = bus.operand2;
                acc_d   = '0;
                cnt_d   = '0;
                mod_d   = (bus.operation == 4'h3);
                state_d = DIV;
              end
            end
            default: begin
              load    = 1'b1;
              ld_val  = alu_r;
              state_d = DONE;
            end
          endcase
        end
      end
      MUL: begin
        acc_d = prod;
        mc_d  = mc_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          load    = 1'b1;
          ld_val  = prod;
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = W'(rem_n);
        mc_d  = W'(quo_n);
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          load    = 1'b1;
          ld_val  = mod_q ? W'(rem_n) : W'(quo_n);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      res_d  = ld_val;
      zero_d = (ld_val == '0);
      err_d  = ld_err;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mc_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.alu_out   = res_q;
  assign bus.zero      = bus.out_valid && zero_q;
  assign bus.div_err   = bus.out_valid && err_q;
endmodule
